memory_stage: RTL and testbench

MEM stage of the 5-stage MIPS pipeline. It sits directly downstream of the execute stage and consumes its M-side pipeline registers (RegWriteM, MemtoRegM, MemWriteM, ALUOutM, WriteDataM, WriteRegM). It drives a variable-latency data memory through a req/ready handshake and stalls the pipeline while an access is outstanding. It also owns the MEM/WB pipeline registers feeding the writeback stage.

---
 rtl/mips_pkg.sv | 23 ++
 rtl/dmem_handshake.sv | 123 ++++++++++++
 rtl/memory_stage.sv | 121 ++++++++++++
 tb/tb_memory_stage.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared types for the MIPS MEM stage: handshake FSM states and the MEM/WB bundle.
// No logic; the bubble constant is what W registers take on stall, squash or abort.
// Stores are carried with reg_write already forced low.
package mips_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } hs_state_t;

  typedef struct packed {
    logic        reg_write;
    logic        mem_to_reg;
    logic [31:0] read_data;
    logic [31:0] alu_out;
    logic [4:0]  write_reg;
  } memwb_t;

  localparam memwb_t MEMWB_BUBBLE = '0;

  localparam int CNT_W = 8;

endpackage

// File: rtl/dmem_handshake.sv
// Data-memory req/ready handshake with an internal request latch and a timeout counter.
// Request is combinational from the M inputs in IDLE; from the latched copy in WAIT.
// stall is high while an access is outstanding. The access is aborted after TIMEOUT_CYCLES in WAIT.
module dmem_handshake
  import mips_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int ADDR_W         = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              we_in,
  input  logic [31:0]       addr_in,
  input  logic [31:0]       wdata_in,
  input  logic              reg_write_in,
  input  logic              mem_to_reg_in,
  input  logic [4:0]        write_reg_in,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  input  logic              dmem_ready,
  output logic              done,
  output logic              stall,
  output logic              timeout,
  output logic              in_wait,
  output logic              lat_reg_write,
  output logic              lat_mem_to_reg,
  output logic [4:0]        lat_write_reg,
  output logic [31:0]       lat_addr
);

  hs_state_t        state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             load_lat;
  logic             lat_we;
  logic [31:0]      lat_wdata;

  assign in_wait = (state == ST_WAIT);

  // State and timeout counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Capture the request when it first stalls; WAIT relies only on this copy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_we         <= 1'b0;
      lat_addr       <= '0;
      lat_wdata      <= '0;
      lat_reg_write  <= 1'b0;
      lat_mem_to_reg <= 1'b0;
      lat_write_reg  <= '0;
    end else if (load_lat) begin
      lat_we         <= we_in;
      lat_addr       <= addr_in;
      lat_wdata      <= wdata_in;
      lat_reg_write  <= reg_write_in;
      lat_mem_to_reg <= mem_to_reg_in;
      lat_write_reg  <= write_reg_in;
    end
  end

  // Next state and handshake outputs; everything is forced quiet while reset is high.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    load_lat   = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    dmem_addr  = addr_in[ADDR_W-1:0];
    dmem_wdata = wdata_in;
    done       = 1'b0;
    stall      = 1'b0;
    timeout    = 1'b0;
    if (!rst) begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            dmem_req = 1'b1;
            dmem_we  = we_in;
            if (dmem_ready) begin
              done = 1'b1;
            end else begin
              stall     = 1'b1;
              load_lat  = 1'b1;
              cnt_nxt   = CNT_W'(1);
              state_nxt = ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          dmem_req   = 1'b1;
          dmem_we    = lat_we;
          dmem_addr  = lat_addr[ADDR_W-1:0];
          dmem_wdata = lat_wdata;
          if (dmem_ready) begin
            done      = 1'b1;
            cnt_nxt   = '0;
            state_nxt = ST_IDLE;
          end else if (cnt == CNT_W'(TIMEOUT_CYCLES)) begin
            timeout   = 1'b1;
            cnt_nxt   = '0;
            state_nxt = ST_IDLE;
          end else begin
            stall   = 1'b1;
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/memory_stage.sv
// MIPS MEM stage: alignment check, data-memory handshake and MEM/WB pipeline registers.
// Zero extra cycles on zero-wait memory; one stall cycle per cycle the memory withholds ready.
// StallM freezes upstream; W takes a bubble on stall, misalignment or timeout.
module memory_stage
  import mips_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int ADDR_W         = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RegWriteM,
  input  logic              MemtoRegM,
  input  logic              MemWriteM,
  input  logic [31:0]       ALUOutM,
  input  logic [31:0]       WriteDataM,
  input  logic [4:0]        WriteRegM,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  input  logic              dmem_ready,
  input  logic [31:0]       dmem_rdata,
  output logic              StallM,
  output logic              RegWriteW,
  output logic              MemtoRegW,
  output logic [31:0]       ReadDataW,
  output logic [31:0]       ALUOutW,
  output logic [4:0]        WriteRegW,
  output logic              AddrErrW,
  output logic              BusErrW
);

  logic        acc, mis, start, reg_write_m;
  logic        done, stall, timeout, in_wait;
  logic        lat_reg_write, lat_mem_to_reg;
  logic [4:0]  lat_write_reg;
  logic [31:0] lat_addr;
  memwb_t      w_q, w_nxt;
  logic        addr_err_nxt, bus_err_nxt;

  assign acc         = MemtoRegM | MemWriteM;
  assign mis         = acc & (ALUOutM[1:0] != 2'b00);
  assign start       = acc & ~mis;
  assign reg_write_m = RegWriteM & ~MemWriteM;

  dmem_handshake #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .ADDR_W        (ADDR_W)
  ) u_hs (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .we_in         (MemWriteM),
    .addr_in       (ALUOutM),
    .wdata_in      (WriteDataM),
    .reg_write_in  (reg_write_m),
    .mem_to_reg_in (MemtoRegM),
    .write_reg_in  (WriteRegM),
    .dmem_req      (dmem_req),
    .dmem_we       (dmem_we),
    .dmem_addr     (dmem_addr),
    .dmem_wdata    (dmem_wdata),
    .dmem_ready    (dmem_ready),
    .done          (done),
    .stall         (stall),
    .timeout       (timeout),
    .in_wait       (in_wait),
    .lat_reg_write (lat_reg_write),
    .lat_mem_to_reg(lat_mem_to_reg),
    .lat_write_reg (lat_write_reg),
    .lat_addr      (lat_addr)
  );

  assign StallM = stall;

  // Choose what MEM/WB takes this cycle: completed access, pass-through, or bubble.
  always_comb begin
    w_nxt        = MEMWB_BUBBLE;
    addr_err_nxt = 1'b0;
    bus_err_nxt  = 1'b0;
    if (in_wait) begin
      bus_err_nxt = timeout;
      if (done) begin
        w_nxt.reg_write  = lat_reg_write;
        w_nxt.mem_to_reg = lat_mem_to_reg;
        w_nxt.read_data  = lat_mem_to_reg ? dmem_rdata : 32'd0;
        w_nxt.alu_out    = lat_addr;
        w_nxt.write_reg  = lat_write_reg;
      end
    end else if (mis) begin
      addr_err_nxt = 1'b1;
    end else if (!acc || done) begin
      w_nxt.reg_write  = reg_write_m;
      w_nxt.mem_to_reg = MemtoRegM;
      w_nxt.read_data  = MemtoRegM ? dmem_rdata : 32'd0;
      w_nxt.alu_out    = ALUOutM;
      w_nxt.write_reg  = WriteRegM;
    end
  end

  // MEM/WB pipeline registers and one-cycle error pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_q      <= MEMWB_BUBBLE;
      AddrErrW <= 1'b0;
      BusErrW  <= 1'b0;
    end else begin
      w_q      <= w_nxt;
      AddrErrW <= addr_err_nxt;
      BusErrW  <= bus_err_nxt;
    end
  end

  assign RegWriteW = w_q.reg_write;
  assign MemtoRegW = w_q.mem_to_reg;
  assign ReadDataW = w_q.read_data;
  assign ALUOutW   = w_q.alu_out;
  assign WriteRegW = w_q.write_reg;

endmodule

// File: tb/tb_memory_stage.sv
module tb_memory_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        RegWriteM, MemtoRegM, MemWriteM;
  logic [31:0] ALUOutM, WriteDataM;
  logic [4:0]  WriteRegM;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;
  logic        StallM, RegWriteW, MemtoRegW;
  logic [31:0] ReadDataW, ALUOutW;
  logic [4:0]  WriteRegW;
  logic        AddrErrW, BusErrW;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  memory_stage #(.TIMEOUT_CYCLES(4), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM), .MemWriteM(MemWriteM),
    .ALUOutM(ALUOutM), .WriteDataM(WriteDataM), .WriteRegM(WriteRegM),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
    .StallM(StallM), .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW),
    .ReadDataW(ReadDataW), .ALUOutW(ALUOutW), .WriteRegW(WriteRegW),
    .AddrErrW(AddrErrW), .BusErrW(BusErrW)
  );

  // Drive a quiet M stage (no access, no register write).
  task automatic set_idle();
    RegWriteM = 0; MemtoRegM = 0; MemWriteM = 0;
    ALUOutM = 0; WriteDataM = 0; WriteRegM = 0;
    dmem_ready = 0; dmem_rdata = 0;
  endtask

  // Advance to just after the next rising edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1;
    set_idle();
    #12;
    checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", dmem_req); end
    checks++; if (StallM !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", StallM); end
    checks++; if ({RegWriteW, MemtoRegW, ReadDataW, ALUOutW, WriteRegW, AddrErrW, BusErrW} !== 73'd0) begin
      errors++; $display("FAIL reset_w: got rw=%b alu=%h rd=%h expected all 0", RegWriteW, ALUOutW, ReadDataW); end
    @(negedge clk);
    rst = 0;
    next_cycle();
  endtask

  task automatic test_zero_wait_load();
    RegWriteM = 1; MemtoRegM = 1; ALUOutM = 32'h10; WriteRegM = 5'd8;
    dmem_ready = 1; dmem_rdata = 32'hDEADBEEF;
    #4;
    checks++; if (StallM !== 1'b0) begin errors++; $display("FAIL zw_stall: got %b expected 0", StallM); end
    checks++; if ({dmem_req, dmem_we, dmem_addr} !== {1'b1, 1'b0, 32'h10}) begin
      errors++; $display("FAIL zw_req: got req=%b we=%b addr=%h expected 1 0 00000010", dmem_req, dmem_we, dmem_addr); end
    next_cycle();
    set_idle();
    checks++; if (ReadDataW !== 32'hDEADBEEF) begin errors++; $display("FAIL zw_rdata: got %h expected deadbeef", ReadDataW); end
    checks++; if ({RegWriteW, MemtoRegW, WriteRegW} !== {1'b1, 1'b1, 5'd8}) begin
      errors++; $display("FAIL zw_ctrl: got rw=%b m2r=%b wr=%0d expected 1 1 8", RegWriteW, MemtoRegW, WriteRegW); end
    next_cycle();
  endtask

  task automatic test_store_3wait();
    RegWriteM = 1; MemWriteM = 1; ALUOutM = 32'h20; WriteDataM = 32'h12345678; WriteRegM = 5'd2;
    for (int k = 0; k < 4; k++) begin
      dmem_ready = (k == 3);
      #4;
      checks++; if ({dmem_req, dmem_we, dmem_addr, dmem_wdata} !== {1'b1, 1'b1, 32'h20, 32'h12345678}) begin
        errors++; $display("FAIL st_bus[%0d]: got req=%b we=%b addr=%h wdata=%h expected 1 1 00000020 12345678", k, dmem_req, dmem_we, dmem_addr, dmem_wdata); end
      checks++; if (StallM !== (k < 3)) begin errors++; $display("FAIL st_stall[%0d]: got %b expected %b", k, StallM, (k < 3)); end
      next_cycle();
      checks++; if (RegWriteW !== 1'b0) begin errors++; $display("FAIL st_regwrite[%0d]: got %b expected 0", k, RegWriteW); end
    end
    checks++; if (ALUOutW !== 32'h20) begin errors++; $display("FAIL st_aluout: got %h expected 00000020", ALUOutW); end
    set_idle();
    #4;
    checks++; if ({dmem_req, StallM} !== 2'b00) begin errors++; $display("FAIL st_idle: got req=%b stall=%b expected 0 0", dmem_req, StallM); end
    next_cycle();
  endtask

  task automatic test_misaligned();
    RegWriteM = 1; MemtoRegM = 1; ALUOutM = 32'h22; WriteRegM = 5'd3; dmem_ready = 1;
    #4;
    checks++; if ({dmem_req, StallM} !== 2'b00) begin errors++; $display("FAIL mis_req: got req=%b stall=%b expected 0 0", dmem_req, StallM); end
    next_cycle();
    set_idle();
    checks++; if ({AddrErrW, RegWriteW, WriteRegW, ALUOutW} !== {1'b1, 1'b0, 5'd0, 32'd0}) begin
      errors++; $display("FAIL mis_w: got aerr=%b rw=%b wr=%0d alu=%h expected 1 0 0 0", AddrErrW, RegWriteW, WriteRegW, ALUOutW); end
    next_cycle();
    checks++; if (AddrErrW !== 1'b0) begin errors++; $display("FAIL mis_pulse: got %b expected 0", AddrErrW); end
  endtask

  task automatic test_timeout();
    RegWriteM = 1; MemtoRegM = 1; ALUOutM = 32'h40; WriteRegM = 5'd7;
    for (int k = 0; k < 5; k++) begin
      #4;
      checks++; if (StallM !== (k < 4)) begin errors++; $display("FAIL to_stall[%0d]: got %b expected %b", k, StallM, (k < 4)); end
      checks++; if (dmem_req !== 1'b1) begin errors++; $display("FAIL to_req[%0d]: got %b expected 1", k, dmem_req); end
      next_cycle();
      if (k < 4) begin
        checks++; if (BusErrW !== 1'b0) begin errors++; $display("FAIL to_early[%0d]: got %b expected 0", k, BusErrW); end
      end
    end
    checks++; if ({BusErrW, RegWriteW} !== 2'b10) begin errors++; $display("FAIL to_buserr: got berr=%b rw=%b expected 1 0", BusErrW, RegWriteW); end
    set_idle();
    #4;
    checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL to_drop: got %b expected 0", dmem_req); end
    next_cycle();
    checks++; if (BusErrW !== 1'b0) begin errors++; $display("FAIL to_pulse: got %b expected 0", BusErrW); end
  endtask

  task automatic test_reset_mid_wait();
    RegWriteM = 1; MemtoRegM = 1; ALUOutM = 32'h50; WriteRegM = 5'd10;
    next_cycle();
    #4;
    checks++; if (StallM !== 1'b1) begin errors++; $display("FAIL rmw_prestall: got %b expected 1", StallM); end
    rst = 1;
    #1;
    checks++; if ({dmem_req, StallM} !== 2'b00) begin errors++; $display("FAIL rmw_req: got req=%b stall=%b expected 0 0", dmem_req, StallM); end
    checks++; if ({RegWriteW, MemtoRegW, ReadDataW, ALUOutW, WriteRegW, AddrErrW, BusErrW} !== 73'd0) begin
      errors++; $display("FAIL rmw_w: got rw=%b alu=%h expected all 0", RegWriteW, ALUOutW); end
    set_idle();
    next_cycle();
    @(negedge clk);
    rst = 0;
    next_cycle();
    RegWriteM = 1; MemtoRegM = 1; ALUOutM = 32'h60; WriteRegM = 5'd9;
    dmem_ready = 1; dmem_rdata = 32'hCAFEF00D;
    #4;
    checks++; if ({dmem_req, StallM} !== 2'b10) begin errors++; $display("FAIL rmw_new_req: got req=%b stall=%b expected 1 0", dmem_req, StallM); end
    next_cycle();
    set_idle();
    checks++; if ({RegWriteW, ReadDataW, WriteRegW} !== {1'b1, 32'hCAFEF00D, 5'd9}) begin
      errors++; $display("FAIL rmw_new_w: got rw=%b rd=%h wr=%0d expected 1 cafef00d 9", RegWriteW, ReadDataW, WriteRegW); end
  endtask

  task automatic test_back_to_back();
    RegWriteM = 1; ALUOutM = 32'h7; WriteRegM = 5'd4; dmem_ready = 1; dmem_rdata = 32'h11111111;
    #4;
    checks++; if ({dmem_req, StallM} !== 2'b00) begin errors++; $display("FAIL b2b_alu_req: got req=%b stall=%b expected 0 0", dmem_req, StallM); end
    next_cycle();
    checks++; if ({RegWriteW, ALUOutW, ReadDataW, WriteRegW} !== {1'b1, 32'h7, 32'h0, 5'd4}) begin
      errors++; $display("FAIL b2b_alu_w: got rw=%b alu=%h rd=%h wr=%0d expected 1 7 0 4", RegWriteW, ALUOutW, ReadDataW, WriteRegW); end
    MemtoRegM = 1; ALUOutM = 32'h30; WriteRegM = 5'd6; dmem_ready = 0; dmem_rdata = 0;
    #4;
    checks++; if (StallM !== 1'b1) begin errors++; $display("FAIL b2b_stall: got %b expected 1", StallM); end
    next_cycle();
    checks++; if (RegWriteW !== 1'b0) begin errors++; $display("FAIL b2b_bubble: got %b expected 0", RegWriteW); end
    dmem_ready = 1; dmem_rdata = 32'hA5A5A5A5;
    #4;
    checks++; if (StallM !== 1'b0) begin errors++; $display("FAIL b2b_release: got %b expected 0", StallM); end
    next_cycle();
    set_idle();
    checks++; if ({RegWriteW, MemtoRegW, ReadDataW, ALUOutW, WriteRegW} !== {1'b1, 1'b1, 32'hA5A5A5A5, 32'h30, 5'd6}) begin
      errors++; $display("FAIL b2b_load_w: got rw=%b m2r=%b rd=%h alu=%h wr=%0d expected 1 1 a5a5a5a5 30 6", RegWriteW, MemtoRegW, ReadDataW, ALUOutW, WriteRegW); end
  endtask

  initial begin
    test_reset();
    test_zero_wait_load();
    test_store_3wait();
    test_misaligned();
    test_timeout();
    test_reset_mid_wait();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
